// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and helpers for the bit-serial subtractor
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 64;

    // Signed overflow of a - b: operand signs differ and the result sign
    // does not follow the minuend.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) & (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - operand/result handshake bundle for the serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, overflow
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// rtl/serial_subtractor_full_subtractor.sv - one-bit combinational subtract step
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic b_out
);
    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~(a ^ b) & b_in);
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, registered borrow chain
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    serial_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             br_q;
    logic             a_msb_q;
    logic             b_msb_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             overflow_q;
    logic             out_valid_q;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic             in_ready;
    logic             in_fire;

    full_subtractor u_fs (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .b_in  (br_q),
        .diff  (d_bit),
        .b_out (br_next)
    );

    // Ready depends only on state and the consumer, never on in_valid.
    assign in_ready = (state == S_IDLE) | ((state == S_DONE) & bus.out_ready);
    assign in_fire  = bus.in_valid & in_ready;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = overflow_q;

    // Result register with this cycle's difference bit inserted at the MSB.
    always_comb begin
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = d_bit;
    end

    // FSM, operand/result shifting, borrow flop and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            cnt         <= '0;
            br_q        <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            // Accept from IDLE, or back-to-back from DONE while the result leaves.
            state       <= S_BUSY;
            a_sh        <= bus.a;
            b_sh        <= bus.b;
            a_msb_q     <= bus.a[WIDTH-1];
            b_msb_q     <= bus.b[WIDTH-1];
            res_sh      <= '0;
            cnt         <= '0;
            br_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                S_BUSY: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br_q   <= br_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        state       <= S_DONE;
                        diff_q      <= res_next;
                        borrow_q    <= br_next;
                        overflow_q  <= sub_overflow(a_msb_q, b_msb_q, d_bit);
                        out_valid_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state       <= S_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                S_IDLE: begin
                end
                default: begin
                    state       <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand pair at a negedge, wait for the result, sample it,
    // then let one edge pass so the result is consumed (out_ready assumed high).
    task automatic run_op(input bit w1, input logic [7:0] a_v, input logic [7:0] b_v,
                          output logic [7:0] d, output logic br, output logic ov, output int lat);
        logic ov_seen;
        if (w1) begin
            bus1.in_valid = 1'b1; bus1.a = a_v[0]; bus1.b = b_v[0];
        end else begin
            bus8.in_valid = 1'b1; bus8.a = a_v; bus8.b = b_v;
        end
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus8.in_valid = 1'b0;
        lat = 0;
        ov_seen = w1 ? bus1.out_valid : bus8.out_valid;
        while (!ov_seen && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            ov_seen = w1 ? bus1.out_valid : bus8.out_valid;
        end
        if (w1) begin
            d = {7'b0, bus1.diff}; br = bus1.borrow; ov = bus1.overflow;
        end else begin
            d = bus8.diff; br = bus8.borrow; ov = bus8.overflow;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus8.out_valid); end
        checks++; if (bus8.diff !== 8'h00) begin failures++; $display("FAIL reset_diff got=%h exp=00", bus8.diff); end
        checks++; if (bus8.borrow !== 1'b0) begin failures++; $display("FAIL reset_borrow got=%b exp=0", bus8.borrow); end
        checks++; if (bus8.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus8.overflow); end
        checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus8.in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] va [6] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'hA5, 8'h00};
        logic [7:0] vb [6] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'hA5, 8'h00};
        logic [7:0] ed [6] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'h00, 8'h00};
        logic       eb [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       eo [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         lat;
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, va[i], vb[i], d, br, ov, lat);
            checks++; if (lat != 8) begin failures++; $display("FAIL basic_latency[%0d] got=%0d exp=8", i, lat); end
            checks++; if (d !== ed[i]) begin failures++; $display("FAIL basic_diff[%0d] got=%h exp=%h", i, d, ed[i]); end
            checks++; if (br !== eb[i]) begin failures++; $display("FAIL basic_borrow[%0d] got=%b exp=%b", i, br, eb[i]); end
            checks++; if (ov !== eo[i]) begin failures++; $display("FAIL basic_overflow[%0d] got=%b exp=%b", i, ov, eo[i]); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bus8.out_ready = 1'b0;
        bus8.in_valid = 1'b1; bus8.a = 8'h40; bus8.b = 8'h10;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 8) begin failures++; $display("FAIL bp_latency got=%0d exp=8", lat); end
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = 1'b1; bus8.a = 8'hEE; bus8.b = 8'h11;
            checks++; if (bus8.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, bus8.out_valid); end
            checks++; if (bus8.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, bus8.in_ready); end
            checks++; if (bus8.diff !== 8'h30) begin failures++; $display("FAIL bp_diff[%0d] got=%h exp=30", i, bus8.diff); end
            checks++; if ({bus8.borrow, bus8.overflow} !== 2'b00) begin failures++; $display("FAIL bp_flags[%0d] got=%b exp=00", i, {bus8.borrow, bus8.overflow}); end
            @(posedge clk);
            @(negedge clk);
        end
        bus8.in_valid = 1'b0;
        bus8.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", bus8.out_valid); end
        checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", bus8.in_ready); end
        checks++; if (bus8.diff !== 8'h30) begin failures++; $display("FAIL bp_release_diff_hold got=%h exp=30", bus8.diff); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus8.out_ready = 1'b1;
        bus8.in_valid = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01;
        @(posedge clk);
        @(negedge clk);
        bus8.a = 8'h00; bus8.b = 8'h01;
        lat = 0;
        while (!bus8.out_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 8) begin failures++; $display("FAIL b2b_latency0 got=%0d exp=8", lat); end
        checks++; if ({bus8.diff, bus8.borrow} !== {8'h0F, 1'b0}) begin failures++; $display("FAIL b2b_result0 got=%h/%b exp=0f/0", bus8.diff, bus8.borrow); end
        checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_done got=%b exp=1", bus8.in_ready); end
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        checks++; if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_out_valid_drop got=%b exp=0", bus8.out_valid); end
        checks++; if (bus8.in_ready !== 1'b0) begin failures++; $display("FAIL b2b_reloaded_busy got=%b exp=0", bus8.in_ready); end
        lat = 0;
        while (!bus8.out_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 8) begin failures++; $display("FAIL b2b_latency1 got=%0d exp=8", lat); end
        checks++; if ({bus8.diff, bus8.borrow} !== {8'hFF, 1'b1}) begin failures++; $display("FAIL b2b_result1 got=%h/%b exp=ff/1", bus8.diff, bus8.borrow); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         lat;
        int         spurious;
        bus8.in_valid = 1'b1; bus8.a = 8'h55; bus8.b = 8'h11;
        @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus8.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", bus8.out_valid); end
        checks++; if (bus8.diff !== 8'h00) begin failures++; $display("FAIL rstmid_diff got=%h exp=00", bus8.diff); end
        checks++; if (bus8.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", bus8.in_ready); end
        spurious = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (bus8.out_valid) spurious++;
        end
        checks++; if (spurious != 0) begin failures++; $display("FAIL rstmid_no_partial got=%0d exp=0", spurious); end
        run_op(1'b0, 8'h22, 8'h11, d, br, ov, lat);
        checks++; if (lat != 8) begin failures++; $display("FAIL rstmid_fresh_latency got=%0d exp=8", lat); end
        checks++; if ({d, br, ov} !== {8'h11, 2'b00}) begin failures++; $display("FAIL rstmid_fresh_result got=%h/%b/%b exp=11/0/0", d, br, ov); end
    endtask

    task automatic test_width1();
        logic [1:0] va [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic [1:0] vb [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
        logic [1:0] exp_db [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
        logic       exp_ov [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         lat;
        for (int i = 0; i < 4; i++) begin
            run_op(1'b1, {6'b0, va[i]}, {6'b0, vb[i]}, d, br, ov, lat);
            checks++; if (lat != 1) begin failures++; $display("FAIL w1_latency[%0d] got=%0d exp=1", i, lat); end
            checks++; if ({d[0], br} !== exp_db[i]) begin failures++; $display("FAIL w1_diff_borrow[%0d] got=%b exp=%b", i, {d[0], br}, exp_db[i]); end
            checks++; if (ov !== exp_ov[i]) begin failures++; $display("FAIL w1_overflow[%0d] got=%b exp=%b", i, ov, exp_ov[i]); end
            checks++; if (bus1.out_valid !== 1'b0) begin failures++; $display("FAIL w1_consumed[%0d] got=%b exp=0", i, bus1.out_valid); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
